// File: rtl/camera_pattern_gen.sv
// -----------------------------------------------------------------------------
// camera_pattern_gen
//
// Parallel-camera test pattern source. Emits a pixel clock at clk/2 together
// with line valid, frame valid and 12-bit pixel data, framed as:
//   FV_SETUP (fval only) -> { LINE (lval) -> HBLANK } x V_ACTIVE -> FV_HOLD
//   -> VBLANK (nothing) -> next frame, or IDLE if enable has dropped.
// All framing/data registers update only on the pixel tick (the clk edge on
// which cam_pixclk falls), so every output is stable at cam_pixclk rising.
//
// Optional feature: define CAMERA_PATTERN_LFSR_EN to build the LFSR pattern
// (pattern 3). Without it, pattern 3 outputs the latched constant.
//
// Parameters (all timing parameters must be >= 1):
//   H_ACTIVE  pixels per line          H_BLANK  blank slots between lines
//   V_ACTIVE  lines per frame          FV_MARGIN fval-only slots before/after
//   V_BLANK   fval-low slots between frames
// Ports:
//   clk          single clock
//   reset        synchronous active-high reset
//   enable       run request (sampled at frame boundaries only)
//   pattern_sel  0 ramp, 1 Bayer bars, 2 constant, 3 LFSR (latched per frame)
//   const_value  constant pixel value (latched per frame)
//   cam_pixclk   pixel clock, cam_data / cam_lval / cam_fval camera bus
//   frame_count  completed frames (wraps), frame_done one-clk end-of-frame
// -----------------------------------------------------------------------------
module camera_pattern_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 16,
  parameter int V_ACTIVE  = 480,
  parameter int FV_MARGIN = 8,
  parameter int V_BLANK   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] const_value,
  output logic        cam_pixclk,
  output logic [11:0] cam_data,
  output logic        cam_lval,
  output logic        cam_fval,
  output logic [15:0] frame_count,
  output logic        frame_done
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared duration counter serves every state; in LINE it is the column.
  localparam int CNT_MAX = max_of(max_of(H_ACTIVE, H_BLANK), max_of(FV_MARGIN, V_BLANK));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LINE_W  = $clog2(V_ACTIVE + 1);

  localparam logic [CNT_W-1:0]  FV_LAST   = CNT_W'(FV_MARGIN - 1);
  localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  HB_LAST   = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0]  VB_LAST   = CNT_W'(V_BLANK - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);
  localparam logic [CNT_W+2:0]  H_DIV     = (CNT_W + 3)'(H_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FV_SETUP,
    S_LINE,
    S_HBLANK,
    S_FV_HOLD,
    S_VBLANK
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [LINE_W-1:0]   line_reg, line_next;
  logic [1:0]          pat_reg;
  logic [11:0]         const_reg;
  logic                pixclk_reg;
  logic [15:0]         frame_count_reg;
  logic                frame_done_reg;
  logic                frame_start;   // entering FV_SETUP on this tick
  logic                frame_end;     // leaving FV_HOLD on this tick
  logic                tick;

  // The edge that takes the pixel clock from 1 to 0 is the pixel tick.
  assign tick = pixclk_reg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    line_next   = line_reg;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    if (tick) begin
      unique case (state_reg)
        S_IDLE: begin
          if (enable) begin
            state_next  = S_FV_SETUP;
            cnt_next    = '0;
            line_next   = '0;
            frame_start = 1'b1;
          end
        end
        S_FV_SETUP: begin
          if (cnt_reg == FV_LAST) begin
            state_next = S_LINE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        S_LINE: begin
          if (cnt_reg == H_LAST) begin
            cnt_next   = '0;
            state_next = (line_reg < LINE_LAST) ? S_HBLANK : S_FV_HOLD;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        S_HBLANK: begin
          if (cnt_reg == HB_LAST) begin
            state_next = S_LINE;
            cnt_next   = '0;
            line_next  = line_reg + 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        S_FV_HOLD: begin
          if (cnt_reg == FV_LAST) begin
            state_next = S_VBLANK;
            cnt_next   = '0;
            frame_end  = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        S_VBLANK: begin
          if (cnt_reg == VB_LAST) begin
            cnt_next = '0;
            if (enable) begin
              state_next  = S_FV_SETUP;
              line_next   = '0;
              frame_start = 1'b1;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = S_IDLE;
          cnt_next   = '0;
          line_next  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and framing registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      line_reg        <= '0;
      pat_reg         <= '0;
      const_reg       <= '0;
      pixclk_reg      <= 1'b0;
      frame_count_reg <= '0;
      frame_done_reg  <= 1'b0;
    end else begin
      pixclk_reg     <= ~pixclk_reg;
      frame_done_reg <= frame_end;   // frame_end only occurs on a tick: 1-clk pulse
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      line_reg       <= line_next;
      if (frame_start) begin
        pat_reg   <= pattern_sel;
        const_reg <= const_value;
      end
      if (frame_end) begin
        frame_count_reg <= frame_count_reg + 16'd1;
      end
    end
  end

`ifdef CAMERA_PATTERN_LFSR_EN
  // Fibonacci LFSR x^12+x^6+x^4+x+1. Reseeded at every frame start so each
  // frame carries an identical sequence; steps once per active pixel.
  logic [11:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_reg <= 12'h001;
    end else if (frame_start) begin
      lfsr_reg <= 12'h001;
    end else if (tick && state_reg == S_LINE) begin
      lfsr_reg <= {lfsr_reg[10:0], lfsr_reg[11] ^ lfsr_reg[5] ^ lfsr_reg[3] ^ lfsr_reg[0]};
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Pixel data. Driven only from registers that move on ticks, so it changes
  // only on ticks too.
  // ---------------------------------------------------------------------------
  logic [2:0] bar;
  logic       bayer_on;

  always_comb begin
    // Bar index = x*8/H_ACTIVE; quotient is always below 8.
    bar = 3'({cnt_reg, 3'b000} / H_DIV);
    // GRBG mosaic: bar bits are {R,G,B}, site picked by (y[0], x[0]).
    unique case ({line_reg[0], cnt_reg[0]})
      2'b01:   bayer_on = bar[2];
      2'b10:   bayer_on = bar[0];
      default: bayer_on = bar[1];
    endcase
  end

  always_comb begin
    cam_fval = (state_reg == S_FV_SETUP) || (state_reg == S_LINE) ||
               (state_reg == S_HBLANK)   || (state_reg == S_FV_HOLD);
    cam_lval = (state_reg == S_LINE);
    cam_data = 12'h000;
    if (cam_lval) begin
      unique case (pat_reg)
        2'd0: cam_data = 12'(cnt_reg);
        2'd1: cam_data = {12{bayer_on}};
        2'd2: cam_data = const_reg;
`ifdef CAMERA_PATTERN_LFSR_EN
        default: cam_data = lfsr_reg;
`else
        default: cam_data = const_reg;
`endif
      endcase
    end
  end

  assign cam_pixclk  = pixclk_reg;
  assign frame_count = frame_count_reg;
  assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_camera_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_camera_pattern_gen
//
// Drives camera_pattern_gen with a small frame geometry and compares every
// pixel tick against a frame model built from the framing and pattern rules:
// per-tick {frame_done, fval, lval, data}, frame_count, output stability
// between ticks, reset state, reset-release latency, mid-frame input changes,
// enable drop, and reset during an active line.
// -----------------------------------------------------------------------------
module tb_camera_pattern_gen;

  localparam int HA = 8;
  localparam int HB = 3;
  localparam int VA = 3;
  localparam int FM = 2;
  localparam int VB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [11:0] const_value;
  logic        cam_pixclk;
  logic [11:0] cam_data;
  logic        cam_lval;
  logic        cam_fval;
  logic [15:0] frame_count;
  logic        frame_done;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_fc = 16'd0;
  logic [13:0] last_vis = 14'd0;

  camera_pattern_gen #(
    .H_ACTIVE (HA),
    .H_BLANK  (HB),
    .V_ACTIVE (VA),
    .FV_MARGIN(FM),
    .V_BLANK  (VB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .const_value(const_value),
    .cam_pixclk (cam_pixclk),
    .cam_data   (cam_data),
    .cam_lval   (cam_lval),
    .cam_fval   (cam_fval),
    .frame_count(frame_count),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next LFSR state from the polynomial x^12+x^6+x^4+x+1 (taps 12,6,4,1).
  function automatic logic [11:0] lfsr_next(input logic [11:0] v);
    return {v[10:0], v[11] ^ v[5] ^ v[3] ^ v[0]};
  endfunction

  function automatic logic [11:0] model_pixel(input int p, input logic [11:0] c,
                                              input int x, input int y, input logic [11:0] lf);
    int bar;
    int bit_sel;
    case (p)
      0: return 12'(x);
      1: begin
        bar = (x * 8) / HA;
        if ((y % 2) == 0 && (x % 2) == 1)      bit_sel = 2;  // R
        else if ((y % 2) == 1 && (x % 2) == 0) bit_sel = 0;  // B
        else                                   bit_sel = 1;  // G
        return (((bar >> bit_sel) & 1) == 1) ? 12'hFFF : 12'h000;
      end
      2: return c;
      default: begin
`ifdef CAMERA_PATTERN_LFSR_EN
        return lf;
`else
        return (lf === 12'hxxx) ? 12'h000 : c;
`endif
      end
    endcase
  endfunction

  // Advance to the next pixel tick (cam_pixclk 1->0), checking that the
  // bus holds and frame_done stays low on the clk edges in between.
  task automatic step_tick();
    logic prev;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 3 && !got; i++) begin
      prev = cam_pixclk;
      @(posedge clk);
      #1;
      if (prev === 1'b1 && cam_pixclk === 1'b0) begin
        got = 1'b1;
      end else begin
        chk("hold_between_ticks", {17'd0, frame_done, cam_fval, cam_lval, cam_data},
            {17'd0, 1'b0, last_vis});
      end
    end
    chk("tick_seen", {31'd0, got}, 32'd1);
    last_vis = {cam_fval, cam_lval, cam_data};
  endtask

  // One whole frame from its FV_SETUP tick to the last VBLANK tick.
  task automatic run_frame(input int p, input logic [11:0] c, input logic [1:0] np,
                           input logic [11:0] nc, input bit drop_en, input int fid);
    logic [14:0] q[$];
    logic [11:0] lf;
    int          vb_idx, line1_idx, fval_exp, fval_obs, done_obs;
    lf = 12'h001;
    fval_exp = 0;
    fval_obs = 0;
    done_obs = 0;
    for (int i = 0; i < FM; i++) q.push_back({1'b0, 1'b1, 1'b0, 12'h000});
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        q.push_back({1'b0, 1'b1, 1'b1, model_pixel(p, c, x, y, lf)});
        lf = lfsr_next(lf);
      end
      if (y < VA - 1)
        for (int i = 0; i < HB; i++) q.push_back({1'b0, 1'b1, 1'b0, 12'h000});
    end
    for (int i = 0; i < FM; i++) q.push_back({1'b0, 1'b1, 1'b0, 12'h000});
    vb_idx = q.size();
    for (int i = 0; i < VB; i++) q.push_back({(i == 0), 1'b0, 1'b0, 12'h000});
    line1_idx = FM + HA + HB;

    foreach (q[i]) begin
      step_tick();
      if (i == vb_idx) exp_fc++;
      chk($sformatf("f%0d_t%0d_bus", fid, i),
          {17'd0, frame_done, cam_fval, cam_lval, cam_data}, {17'd0, q[i]});
      chk($sformatf("f%0d_t%0d_frame_count", fid, i), {16'd0, frame_count}, {16'd0, exp_fc});
      fval_obs += int'(cam_fval);
      done_obs += int'(frame_done);
      fval_exp += int'(q[i][13]);
      if (i == line1_idx) begin
        pattern_sel = 2'($urandom);
        const_value = 12'($urandom);
        if (drop_en) enable = 1'b0;
      end
      if (i == vb_idx) begin
        pattern_sel = np;
        const_value = nc;
      end
    end
    chk($sformatf("f%0d_fval_ticks", fid), fval_obs, fval_exp);
    chk($sformatf("f%0d_done_pulses", fid), done_obs, 1);
  endtask

  initial begin
    int         n;
    logic       prev;
    logic [1:0] cur_p, nxt_p;
    logic [11:0] cur_c, nxt_c;

    reset = 1'b1;
    enable = 1'b0;
    pattern_sel = 2'd0;
    const_value = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pixclk", {31'd0, cam_pixclk}, 32'd0);
    chk("reset_bus", {18'd0, cam_fval, cam_lval, cam_data}, 32'd0);
    chk("reset_frame_count", {16'd0, frame_count}, 32'd0);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);

    // First tick must land on the second clk edge after release.
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      prev = cam_pixclk;
      @(posedge clk);
      #1;
      n++;
      if (prev === 1'b1 && cam_pixclk === 1'b0) break;
    end
    chk("first_tick_latency", n, 2);
    last_vis = {cam_fval, cam_lval, cam_data};
    chk("idle_bus", {18'd0, last_vis}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step_tick();
      chk("idle_bus", {18'd0, cam_fval, cam_lval, cam_data}, 32'd0);
    end

    // Directed patterns, then randomized ones; inputs scrambled mid-frame.
    enable = 1'b1;
    run_frame(0, 12'h000, 2'd1, 12'h123, 1'b0, 0);
    run_frame(1, 12'h123, 2'd2, 12'hABC, 1'b0, 1);
    run_frame(2, 12'hABC, 2'd3, 12'h5A5, 1'b0, 2);
    run_frame(3, 12'h5A5, 2'd3, 12'h5A5, 1'b0, 3);
    cur_p = 2'd3;
    cur_c = 12'h5A5;
    for (int r = 0; r < 3; r++) begin
      nxt_p = 2'($urandom);
      nxt_c = 12'($urandom);
      run_frame(int'(cur_p), cur_c, nxt_p, nxt_c, 1'b0, 4 + r);
      cur_p = nxt_p;
      cur_c = nxt_c;
    end

    // Drop enable during line 1: frame completes, then IDLE holds.
    run_frame(int'(cur_p), cur_c, 2'd0, 12'h000, 1'b1, 7);
    for (int i = 0; i < 4; i++) begin
      step_tick();
      chk("post_drop_idle_bus", {18'd0, cam_fval, cam_lval, cam_data}, 32'd0);
      chk("post_drop_frame_count", {16'd0, frame_count}, {16'd0, exp_fc});
    end

    // Reset in the middle of a line.
    pattern_sel = 2'd0;
    const_value = 12'h000;
    enable = 1'b1;
    repeat (FM + 3) step_tick();
    chk("in_line_before_reset", {31'd0, cam_lval}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midline_reset_pixclk", {31'd0, cam_pixclk}, 32'd0);
    chk("midline_reset_bus", {18'd0, cam_fval, cam_lval, cam_data}, 32'd0);
    chk("midline_reset_frame_count", {16'd0, frame_count}, 32'd0);
    chk("midline_reset_frame_done", {31'd0, frame_done}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_vis = 14'd0;
    exp_fc = 16'd0;
    run_frame(0, 12'h000, 2'd0, 12'h000, 1'b0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
